alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU for the model computer datapath. It performs single-cycle ADD/SUB/AND/OR/XOR and multi-cycle variable shifts and a shift-add multiply. Results go to a registered accumulator with a status-flag register, and the result drives the bus through an active-low output enable. It replaces the fixed 8-bit combinational ALU and latch pair, and adds a start/busy/done handshake for iterative operations.

## Interface
- WIDTH, 8: operand/result width, ≥ 4.
- SW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- CLK, in, 1: system clock, rising edge.
- RSTn, in, 1: asynchronous, active-low reset.
- STARTn, in, 1: active-low start strobe, sampled on the rising edge of CLK.
- OP, in, 3: opcode. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- DinA, in, WIDTH: operand A.
- Din, in, WIDTH: operand B.
- SHAMT, in, SW: shift count for SHL/SHR.
- EALUn, in, 1: active-low output enable for Dout.
- Q, out, WIDTH: result register, always visible.
- Dout, out, WIDTH: Q when EALUn=0, high-Z otherwise.
- FLAGS, out, 4: {V, N, C, Z} flag register.
- BUSY, out, 1: iterative operation in progress.
- DONE, out, 1: one-cycle pulse when Q and FLAGS have just been updated.

## Operation
- States: IDLE, SHIFT, MUL.
- In IDLE, STARTn=0 at edge N latches OP, DinA, Din and SHAMT.
  - ADD/SUB/logic ops: Q and FLAGS are written at edge N. Stay in IDLE.
  - SHL/SHR with SHAMT=0: Q=A, C=0, written at edge N. Stay in IDLE.
  - SHL/SHR with SHAMT=k>0: load the work register with A and the counter with k. Go to SHIFT.
  - MUL: clear the accumulator, set counter=WIDTH. Go to MUL.
- SHIFT: each edge shifts the work register by 1 bit and records the bit shifted out, then decrements the counter. On the edge where the counter reaches 0, write Q and FLAGS and return to IDLE.
- MUL: each edge adds B to the accumulator if the current multiplier LSB is 1, then shifts. The accumulator is 2·WIDTH wide. After WIDTH iterations, Q = low half and the FSM returns to IDLE.
- STARTn is ignored while BUSY=1. Changes to operands or OP after the latch edge have no effect.
- Arithmetic uses unsigned WIDTH bits, with the carry/borrow taken from bit WIDTH.
- Flags are updated only on completion and hold otherwise:
  - Z: result == 0.
  - N: result[WIDTH-1].
  - C:
    - ADD: carry out.
    - SUB: borrow (A<B).
    - SHL/SHR: last bit shifted out.
    - MUL: high half ≠ 0.
    - Logic ops: 0.
  - V:
    - ADD: signed overflow.
    - SUB: signed overflow.
    - All other ops: 0.
- Reset (asynchronous, any state): IDLE, Q=0, FLAGS=0, BUSY=0, DONE=0, internal registers 0. Any in-flight operation is discarded with no DONE.

## Timing
- Latency L from the start edge N to the Q/FLAGS update edge:
  - Single-cycle ops, and shifts with k=0: L=0.
  - SHL/SHR with k>0: L=k.
  - MUL: L=WIDTH.
- DONE is high for exactly the one cycle following the update edge.
- BUSY is high from edge N to edge N+L for iterative ops only. It is never asserted for L=0.
- A new STARTn is accepted in the same cycle DONE is high, so back-to-back single-cycle ops complete every cycle.
- Dout follows EALUn combinationally. There is no clock dependence on the enable path.

## Structure
- Package alu_pkg holds:
  - the opcode enum alu_op_t;
  - the state enum alu_state_t;
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_N=2, FLG_V=3.
- Sub-module alu_iter holds the counter, work register and shift-add datapath for SHIFT/MUL. It has start/done ports and returns the result and last-out bit. The top level keeps the single-cycle datapath, the FSM, the flag logic and the output buffer.

## Test plan
- ADD: WIDTH=8, ADD 0xF0+0x20 → Q=0x10, C=1, Z=0, V=0. DONE is high the cycle after start; BUSY stays 0.
- SUB, two cases:
  - 0x80−0x01 → Q=0x7F, V=1, C=0, N=0.
  - Next cycle, 0x05−0x05 → Q=0x00, Z=1. Confirms back-to-back issue.
- SHR: 0x81 by SHAMT=3 → Q=0x10, C=0. BUSY for 3 cycles, DONE after edge N+3. A STARTn pulse mid-shift is ignored.
- MUL: 0x10×0x11 → Q=0x10, C=1 (high half 0x01). DONE after edge N+8. Operands changed at N+1 do not alter the result.
- Reset mid-MUL at cycle 4 → Q=0, FLAGS=0, BUSY=0, no DONE. The next ADD 1+1 gives Q=0x02.
- Output enable: EALUn=1 → Dout=Z while Q=0x02; EALUn=0 → Dout=0x02 in the same cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states and
// bit positions inside the {V, N, C, Z} flag register.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } alu_state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the datapath controller and the ALU.
// The tri-state Dout bus stays a plain port on the ALU itself.
interface alu_seq_if #(parameter int WIDTH = 8);
    import alu_pkg::*;

    localparam int SW = $clog2(WIDTH);

    logic             STARTn;
    alu_op_t          OP;
    logic [WIDTH-1:0] DinA;
    logic [WIDTH-1:0] Din;
    logic [SW-1:0]    SHAMT;
    logic             EALUn;
    logic [WIDTH-1:0] Q;
    logic [3:0]       FLAGS;
    logic             BUSY;
    logic             DONE;

    modport master (
        output STARTn, OP, DinA, Din, SHAMT, EALUn,
        input  Q, FLAGS, BUSY, DONE
    );

    modport slave (
        input  STARTn, OP, DinA, Din, SHAMT, EALUn,
        output Q, FLAGS, BUSY, DONE
    );

endinterface

// File: rtl/alu_iter.sv
// Iterative engine for one-bit-per-cycle shifts and shift-add multiply.
// done/result/last_out/hi_nz describe the state after the coming edge.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  alu_op_t                    op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       last_out,
    output logic                       hi_nz
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             active_q, active_d;
    logic             mul_q, mul_d;
    logic             shr_q, shr_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;

    // For MUL, {hi_q, work_q} is the 2*WIDTH accumulator; work_q starts as the multiplier.
    always_comb begin
        active_d = active_q;
        mul_d    = mul_q;
        shr_d    = shr_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        hi_d     = hi_q;
        b_d      = b_q;
        sum      = {1'b0, hi_q} + (work_q[0] ? {1'b0, b_q} : '0);
        if (start) begin
            active_d = 1'b1;
            mul_d    = (op == OP_MUL);
            shr_d    = (op == OP_SHR);
            last_d   = 1'b0;
            work_d   = a;
            hi_d     = '0;
            b_d      = b;
            cnt_d    = (op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
        end else if (active_q) begin
            cnt_d = cnt_q - 1'b1;
            if (mul_q) begin
                hi_d   = sum[WIDTH:1];
                work_d = {sum[0], work_q[WIDTH-1:1]};
            end else if (shr_q) begin
                last_d = work_q[0];
                work_d = work_q >> 1;
            end else begin
                last_d = work_q[WIDTH-1];
                work_d = work_q << 1;
            end
            if (cnt_q == CW'(1)) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            mul_q    <= 1'b0;
            shr_q    <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            mul_q    <= mul_d;
            shr_q    <= shr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
        end
    end

    assign done     = active_q && (cnt_q == CW'(1));
    assign result   = work_d;
    assign last_out = last_d;
    assign hi_nz    = |hi_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic in place, shifts and multiply
// delegated to alu_iter, registered result and flags, tri-state bus driver.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    alu_seq_if.slave         bus,
    output wire [WIDTH-1:0]  Dout
);

    alu_state_t        state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              iter_start, iter_done, iter_last, iter_hi_nz;
    logic [WIDTH-1:0]  iter_result;
    logic [WIDTH:0]    uadd, usub;
    logic signed [WIDTH:0] sadd, ssub;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = (r == '0);
        f[FLG_N] = r[WIDTH-1];
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

    // Overflow when the exact signed result does not fit back into WIDTH bits.
    function automatic logic signed_ovf(input logic signed [WIDTH:0] s);
        return s != {s[WIDTH-1], s[WIDTH-1:0]};
    endfunction

    assign uadd = {1'b0, bus.DinA} + {1'b0, bus.Din};
    assign usub = {1'b0, bus.DinA} - {1'b0, bus.Din};
    assign sadd = $signed({bus.DinA[WIDTH-1], bus.DinA}) + $signed({bus.Din[WIDTH-1], bus.Din});
    assign ssub = $signed({bus.DinA[WIDTH-1], bus.DinA}) - $signed({bus.Din[WIDTH-1], bus.Din});

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        flags_d    = flags_q;
        done_d     = 1'b0;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.STARTn) begin
                    done_d = 1'b1;
                    case (bus.OP)
                        OP_ADD: begin
                            q_d     = uadd[WIDTH-1:0];
                            flags_d = make_flags(uadd[WIDTH-1:0], uadd[WIDTH], signed_ovf(sadd));
                        end
                        OP_SUB: begin
                            q_d     = usub[WIDTH-1:0];
                            flags_d = make_flags(usub[WIDTH-1:0], usub[WIDTH], signed_ovf(ssub));
                        end
                        OP_AND: begin
                            q_d     = bus.DinA & bus.Din;
                            flags_d = make_flags(bus.DinA & bus.Din, 1'b0, 1'b0);
                        end
                        OP_OR: begin
                            q_d     = bus.DinA | bus.Din;
                            flags_d = make_flags(bus.DinA | bus.Din, 1'b0, 1'b0);
                        end
                        OP_XOR: begin
                            q_d     = bus.DinA ^ bus.Din;
                            flags_d = make_flags(bus.DinA ^ bus.Din, 1'b0, 1'b0);
                        end
                        OP_SHL, OP_SHR: begin
                            if (bus.SHAMT == '0) begin
                                q_d     = bus.DinA;
                                flags_d = make_flags(bus.DinA, 1'b0, 1'b0);
                            end else begin
                                done_d     = 1'b0;
                                iter_start = 1'b1;
                                state_d    = ST_SHIFT;
                            end
                        end
                        default: begin
                            done_d     = 1'b0;
                            iter_start = 1'b1;
                            state_d    = ST_MUL;
                        end
                    endcase
                end
            end
            ST_SHIFT, ST_MUL: begin
                if (iter_done) begin
                    q_d     = iter_result;
                    flags_d = make_flags(iter_result,
                                         (state_q == ST_MUL) ? iter_hi_nz : iter_last, 1'b0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (CLK),
        .rst_n    (RSTn),
        .start    (iter_start),
        .op       (bus.OP),
        .a        (bus.DinA),
        .b        (bus.Din),
        .shamt    (bus.SHAMT),
        .done     (iter_done),
        .result   (iter_result),
        .last_out (iter_last),
        .hi_nz    (iter_hi_nz)
    );

    assign bus.Q     = q_q;
    assign bus.FLAGS = flags_q;
    assign bus.BUSY  = (state_q != ST_IDLE);
    assign bus.DONE  = done_q;
    assign Dout      = bus.EALUn ? 'z : q_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       tb_drv_en;
    logic [7:0] tb_drv_val;
    wire  [7:0] dout_bus;
    int         checks;
    int         failures;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus),
        .Dout (dout_bus)
    );

    assign dout_bus = tb_drv_en ? tb_drv_val : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result, {V,N,C,Z} and latency from plain integer arithmetic.
    function automatic void ref_model(input int op, input int a, input int b, input int sh,
                                      output int q, output logic [3:0] f, output int lat);
        int r, sa, sb, s;
        bit c, v;
        c = 0; v = 0; lat = 0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << sh; lat = sh; if (sh > 0) c = ((a >> (8 - sh)) & 1) != 0; end
            6: begin r = a >> sh; lat = sh; if (sh > 0) c = ((a >> (sh - 1)) & 1) != 0; end
            default: begin r = a * b; c = (r >> 8) != 0; lat = 8; end
        endcase
        q = r & 255;
        f = {v, q > 127, c, q == 0};
    endfunction

    // Presents one op at the next edge; returns at the negedge after that edge.
    task automatic drive_start(input int op, input int a, input int b, input int sh);
        bus.OP     = alu_op_t'(op[2:0]);
        bus.DinA   = a[7:0];
        bus.Din    = b[7:0];
        bus.SHAMT  = sh[2:0];
        bus.STARTn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.STARTn = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", bus.Q); end
        checks++; if (bus.FLAGS !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.FLAGS); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    endtask

    task automatic test_add();
        drive_start(0, 8'hF0, 8'h20, 0);
        checks++; if (bus.DONE !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", bus.DONE); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.Q !== 8'h10) begin failures++; $display("FAIL add_q got=%h exp=10", bus.Q); end
        checks++; if (bus.FLAGS !== 4'b0010) begin failures++; $display("FAIL add_flags got=%b exp=0010", bus.FLAGS); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", bus.DONE); end
    endtask

    task automatic test_sub_back_to_back();
        bus.OP = OP_SUB; bus.DinA = 8'h80; bus.Din = 8'h01; bus.STARTn = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.Q !== 8'h7F) begin failures++; $display("FAIL sub1_q got=%h exp=7f", bus.Q); end
        checks++; if (bus.FLAGS !== 4'b1000) begin failures++; $display("FAIL sub1_flags got=%b exp=1000", bus.FLAGS); end
        bus.DinA = 8'h05; bus.Din = 8'h05;
        @(posedge clk); @(negedge clk);
        bus.STARTn = 1'b1;
        checks++; if (bus.DONE !== 1'b1) begin failures++; $display("FAIL sub2_done got=%b exp=1", bus.DONE); end
        checks++; if (bus.Q !== 8'h00) begin failures++; $display("FAIL sub2_q got=%h exp=00", bus.Q); end
        checks++; if (bus.FLAGS !== 4'b0001) begin failures++; $display("FAIL sub2_flags got=%b exp=0001", bus.FLAGS); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_shr();
        drive_start(6, 8'h81, 0, 3);
        checks++; if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin failures++; $display("FAIL shr_n0 busy=%b done=%b exp busy=1 done=0", bus.BUSY, bus.DONE); end
        // A start strobe mid-shift must be ignored.
        bus.OP = OP_ADD; bus.DinA = 8'h00; bus.Din = 8'h00; bus.STARTn = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.STARTn = 1'b1;
        checks++; if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin failures++; $display("FAIL shr_n1 busy=%b done=%b exp busy=1 done=0", bus.BUSY, bus.DONE); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin failures++; $display("FAIL shr_n2 busy=%b done=%b exp busy=1 done=0", bus.BUSY, bus.DONE); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin failures++; $display("FAIL shr_n3 busy=%b done=%b exp busy=0 done=1", bus.BUSY, bus.DONE); end
        checks++; if (bus.Q !== 8'h10) begin failures++; $display("FAIL shr_q got=%h exp=10", bus.Q); end
        checks++; if (bus.FLAGS !== 4'b0000) begin failures++; $display("FAIL shr_flags got=%b exp=0000", bus.FLAGS); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.DONE !== 1'b0 || bus.Q !== 8'h10) begin failures++; $display("FAIL shr_after done=%b q=%h exp done=0 q=10", bus.DONE, bus.Q); end
    endtask

    task automatic test_mul();
        int cyc;
        drive_start(7, 8'h10, 8'h11, 0);
        bus.DinA = 8'hFF; bus.Din = 8'hFF; bus.OP = OP_SUB;
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 20) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 8) begin failures++; $display("FAIL mul_latency got=%0d exp=8", cyc); end
        checks++; if (bus.Q !== 8'h10) begin failures++; $display("FAIL mul_q got=%h exp=10", bus.Q); end
        checks++; if (bus.FLAGS !== 4'b0010) begin failures++; $display("FAIL mul_flags got=%b exp=0010", bus.FLAGS); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        bit seen_done;
        drive_start(7, 8'hFF, 8'hFF, 0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.Q !== 8'h00 || bus.FLAGS !== 4'h0) begin failures++; $display("FAIL rst_mul_state q=%h flags=%b exp q=00 flags=0000", bus.Q, bus.FLAGS); end
        checks++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin failures++; $display("FAIL rst_mul_ctrl busy=%b done=%b exp 0 0", bus.BUSY, bus.DONE); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) seen_done = 1;
        end
        checks++; if (seen_done) begin failures++; $display("FAIL rst_mul_no_done got=1 exp=0"); end
        drive_start(0, 1, 1, 0);
        checks++; if (bus.Q !== 8'h02 || bus.DONE !== 1'b1) begin failures++; $display("FAIL rst_add q=%h done=%b exp q=02 done=1", bus.Q, bus.DONE); end
    endtask

    task automatic test_output_enable();
        @(negedge clk);
        tb_drv_val = 8'hA5; tb_drv_en = 1'b1; bus.EALUn = 1'b1;
        #1;
        checks++; if (dout_bus !== 8'hA5) begin failures++; $display("FAIL oe_released got=%h exp=a5", dout_bus); end
        tb_drv_en = 1'b0; bus.EALUn = 1'b0;
        #1;
        checks++; if (dout_bus !== 8'h02) begin failures++; $display("FAIL oe_driven got=%h exp=02", dout_bus); end
    endtask

    task automatic test_back_to_back();
        int q, lat, op, a, b;
        logic [3:0] f;
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 4); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            bus.OP = alu_op_t'(op[2:0]); bus.DinA = a[7:0]; bus.Din = b[7:0]; bus.STARTn = 1'b0;
            @(posedge clk); @(negedge clk);
            ref_model(op, a, b, 0, q, f, lat);
            checks++;
            if (bus.Q !== q[7:0] || bus.FLAGS !== f || bus.DONE !== 1'b1)
                begin failures++; $display("FAIL b2b op=%0d a=%h b=%h q=%h flags=%b done=%b exp q=%h flags=%b done=1", op, a, b, bus.Q, bus.FLAGS, bus.DONE, q[7:0], f); end
        end
        bus.STARTn = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random();
        int q, lat, op, a, b, sh, cyc;
        logic [3:0] f;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7); a = $urandom_range(0, 255);
            b = $urandom_range(0, 255); sh = $urandom_range(0, 7);
            ref_model(op, a, b, sh, q, f, lat);
            drive_start(op, a, b, sh);
            bus.DinA = $urandom_range(0, 255); bus.Din = $urandom_range(0, 255);
            cyc = 0;
            while (bus.DONE !== 1'b1 && cyc < 20) begin
                checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL rnd_busy op=%0d cyc=%0d got=%b exp=1", op, cyc, bus.BUSY); end
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            checks++; if (cyc !== lat) begin failures++; $display("FAIL rnd_latency op=%0d sh=%0d got=%0d exp=%0d", op, sh, cyc, lat); end
            checks++;
            if (bus.Q !== q[7:0] || bus.FLAGS !== f || bus.BUSY !== 1'b0)
                begin failures++; $display("FAIL rnd_result op=%0d a=%h b=%h sh=%0d q=%h flags=%b busy=%b exp q=%h flags=%b busy=0", op, a, b, sh, bus.Q, bus.FLAGS, bus.BUSY, q[7:0], f); end
            @(posedge clk); @(negedge clk);
            checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL rnd_done_pulse op=%0d got=%b exp=0", op, bus.DONE); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        tb_drv_en = 1'b0; tb_drv_val = 8'h00;
        bus.STARTn = 1'b1; bus.OP = OP_ADD; bus.DinA = '0; bus.Din = '0;
        bus.SHAMT = '0; bus.EALUn = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_add();
        test_sub_back_to_back();
        test_shr();
        test_mul();
        test_reset_mid_mul();
        test_output_enable();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
